// File: rtl/reg_file_sequencer.sv
// Client-side sequencer for a two-read/one-write register file: fetch operands,
// run one ALU op and commit the result, one instruction per four cycles.
//
// state | meaning
// IDLE  | instr_ready high, latch instruction on instr_valid
// FETCH | read addresses presented, register file samples them at end of cycle
// EXEC  | read data valid, ALU result and flags registered at end of cycle
// WB    | write_ctrl (not for CMP) and result_valid high for this one cycle
module reg_file_sequencer #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [2:0]        instr_op,
  input  logic [ADDR_W-1:0] instr_rs1,
  input  logic [ADDR_W-1:0] instr_rs2,
  input  logic [ADDR_W-1:0] instr_rd,
  input  logic [DATA_W-1:0] instr_imm,
  output logic [ADDR_W-1:0] r1_addr,
  output logic [ADDR_W-1:0] r2_addr,
  input  logic [DATA_W-1:0] r1_out,
  input  logic [DATA_W-1:0] r2_out,
  output logic [ADDR_W-1:0] write_addr,
  output logic [DATA_W-1:0] write_data,
  output logic              write_ctrl,
  output logic              result_valid,
  output logic [DATA_W-1:0] result,
  output logic              flag_zero,
  output logic              flag_carry
);

  localparam int SH_W = $clog2(DATA_W);

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_SHL = 3'd5;
  localparam logic [2:0] OP_LDI = 3'd6;
  localparam logic [2:0] OP_CMP = 3'd7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2,
    WB    = 2'd3
  } state_t;

  state_t              state;
  logic [2:0]          op_q;
  logic [ADDR_W-1:0]   rd_q;
  logic [DATA_W-1:0]   imm_q;

  logic [DATA_W:0]     wide;
  logic [DATA_W-1:0]   alu_res;
  logic                alu_carry;
  logic [SH_W-1:0]     sh_amt;

  // One extra bit on the wide result carries the ADD carry, SUB borrow
  // and the last bit shifted out by SHL.
  always_comb begin
    wide      = '0;
    alu_res   = '0;
    alu_carry = 1'b0;
    sh_amt    = r2_out[SH_W-1:0];
    case (op_q)
      OP_ADD: begin
        wide      = {1'b0, r1_out} + {1'b0, r2_out};
        alu_res   = wide[DATA_W-1:0];
        alu_carry = wide[DATA_W];
      end
      OP_SUB, OP_CMP: begin
        wide      = {1'b0, r1_out} - {1'b0, r2_out};
        alu_res   = wide[DATA_W-1:0];
        alu_carry = wide[DATA_W];
      end
      OP_AND: alu_res = r1_out & r2_out;
      OP_OR:  alu_res = r1_out | r2_out;
      OP_XOR: alu_res = r1_out ^ r2_out;
      OP_SHL: begin
        wide      = {1'b0, r1_out} << sh_amt;
        alu_res   = wide[DATA_W-1:0];
        alu_carry = wide[DATA_W];
      end
      OP_LDI: alu_res = imm_q;
      default: alu_res = '0;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      op_q         <= '0;
      rd_q         <= '0;
      imm_q        <= '0;
      instr_ready  <= 1'b1;
      r1_addr      <= '0;
      r2_addr      <= '0;
      write_addr   <= '0;
      write_data   <= '0;
      write_ctrl   <= 1'b0;
      result_valid <= 1'b0;
      result       <= '0;
      flag_zero    <= 1'b0;
      flag_carry   <= 1'b0;
    end else begin
      write_ctrl   <= 1'b0;
      result_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (instr_valid) begin
            op_q        <= instr_op;
            rd_q        <= instr_rd;
            imm_q       <= instr_imm;
            r1_addr     <= instr_rs1;
            r2_addr     <= instr_rs2;
            instr_ready <= 1'b0;
            state       <= FETCH;
          end
        end
        FETCH: state <= EXEC;
        EXEC: begin
          result       <= alu_res;
          write_data   <= alu_res;
          write_addr   <= rd_q;
          flag_zero    <= (alu_res == '0);
          flag_carry   <= alu_carry;
          write_ctrl   <= (op_q != OP_CMP);
          result_valid <= 1'b1;
          state        <= WB;
        end
        WB: begin
          instr_ready <= 1'b1;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
